// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the line, frames 11-bit words, decodes E0/F0 prefixes.
// Latency: scan/flags/scan_received update one clk after the stop-bit falling edge (which itself trails raw ps2clk by sync + filter delay).
// Backpressure: none; pulses are single-cycle and the consumer must accept them.
module ps2_scan_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 28000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_in,
  input  logic       ps2data_in,
  output logic       scan_received,
  output logic [7:0] scan,
  output logic       extended,
  output logic       released,
  output logic       frame_error,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]            clk_sync, data_sync;
  logic [FILTER_LEN-1:0] hist;
  logic                  filt;
  logic                  clk_s, data_s, fall;

  state_t       state, state_nxt;
  logic [2:0]   bit_cnt, bit_cnt_nxt;
  logic [7:0]   shreg, shreg_nxt;
  logic         par_ok, par_ok_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic         ext_pend, ext_pend_nxt;
  logic         rel_pend, rel_pend_nxt;
  logic [7:0]   scan_nxt;
  logic         extended_nxt, released_nxt;
  logic         rcv_nxt, err_nxt;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];
  // Falling edge: filtered level is high and the whole sample window has gone low.
  assign fall   = filt && (hist == '0);
  assign busy   = (state != IDLE);

  // Two-flop synchronizers; idle-bus value on reset so release cannot fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2clk_in};
      data_sync <= {data_sync[0], ps2data_in};
    end
  end

  // Glitch filter: level flips only when the last FILTER_LEN samples all agree.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '1;
      filt <= 1'b1;
    end else begin
      hist <= {hist[FILTER_LEN-2:0], clk_s};
      if (&hist)
        filt <= 1'b1;
      else if (hist == '0)
        filt <= 1'b0;
    end
  end

  // Frame state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      shreg         <= 8'h00;
      par_ok        <= 1'b0;
      tcnt          <= '0;
      ext_pend      <= 1'b0;
      rel_pend      <= 1'b0;
      scan          <= 8'h00;
      extended      <= 1'b0;
      released      <= 1'b0;
      scan_received <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      shreg         <= shreg_nxt;
      par_ok        <= par_ok_nxt;
      tcnt          <= tcnt_nxt;
      ext_pend      <= ext_pend_nxt;
      rel_pend      <= rel_pend_nxt;
      scan          <= scan_nxt;
      extended      <= extended_nxt;
      released      <= released_nxt;
      scan_received <= rcv_nxt;
      frame_error   <= err_nxt;
    end
  end

  // Next-state: framing, parity/stop checks, timeout and prefix decode.
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    shreg_nxt    = shreg;
    par_ok_nxt   = par_ok;
    ext_pend_nxt = ext_pend;
    rel_pend_nxt = rel_pend;
    scan_nxt     = scan;
    extended_nxt = extended;
    released_nxt = released;
    rcv_nxt      = 1'b0;
    err_nxt      = 1'b0;
    tcnt_nxt     = (state == IDLE || fall) ? '0 : tcnt + TW'(1);

    if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYCLES)) begin
      // Device stopped clocking mid-frame: abandon it and any pending prefix.
      state_nxt    = IDLE;
      tcnt_nxt     = '0;
      err_nxt      = 1'b1;
      ext_pend_nxt = 1'b0;
      rel_pend_nxt = 1'b0;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_nxt   = DATA;
            bit_cnt_nxt = 3'd0;
          end
        end
        DATA: begin
          shreg_nxt   = {data_s, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            state_nxt = PARITY;
        end
        PARITY: begin
          par_ok_nxt = ^{shreg, data_s};
          state_nxt  = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (!data_s || !par_ok) begin
            err_nxt      = 1'b1;
            ext_pend_nxt = 1'b0;
            rel_pend_nxt = 1'b0;
          end else begin
            case (shreg)
              8'hE0: ext_pend_nxt = 1'b1;
              8'hF0: rel_pend_nxt = 1'b1;
              8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: begin
                ext_pend_nxt = 1'b0;
                rel_pend_nxt = 1'b0;
              end
              default: begin
                scan_nxt     = shreg;
                extended_nxt = ext_pend;
                released_nxt = rel_pend;
                rcv_nxt      = 1'b1;
                ext_pend_nxt = 1'b0;
                rel_pend_nxt = 1'b0;
              end
            endcase
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Self-checking bench for ps2_scan_decoder: directed scenarios plus random frames vs. a byte-level model.
// Latency: checks are taken after an idle gap following each frame.
// Backpressure: not applicable.
module tb_ps2_scan_decoder;

  localparam int FL = 8;
  localparam int TO = 3000;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       scan_received;
  logic [7:0] scan;
  logic       extended;
  logic       released;
  logic       frame_error;
  logic       busy;

  ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .ps2clk_in     (ps2clk_in),
    .ps2data_in    (ps2data_in),
    .scan_received (scan_received),
    .scan          (scan),
    .extended      (extended),
    .released      (released),
    .frame_error   (frame_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Pulse accounting, sampled away from the active edge.
  int rcv_cycles  = 0;
  int err_cycles  = 0;
  int both_cycles = 0;
  always @(negedge clk) begin
    if (scan_received) rcv_cycles++;
    if (frame_error) err_cycles++;
    if (scan_received && frame_error) both_cycles++;
  end

  // Byte-level reference model.
  logic       m_ext, m_rel, m_extd, m_reld;
  logic [7:0] m_scan;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_resp(input logic [7:0] b);
    return b == 8'h00 || b == 8'hAA || b == 8'hEE || b == 8'hFA || b == 8'hFE || b == 8'hFF;
  endfunction

  // Returns 1 if the model expects an emission for this (good) byte.
  function automatic bit model_good(input logic [7:0] b);
    if (b == 8'hE0) begin m_ext = 1'b1; return 1'b0; end
    if (b == 8'hF0) begin m_rel = 1'b1; return 1'b0; end
    if (is_resp(b)) begin m_ext = 1'b0; m_rel = 1'b0; return 1'b0; end
    m_scan = b; m_extd = m_ext; m_reld = m_rel;
    m_ext = 1'b0; m_rel = 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_rel = 0; m_extd = 0; m_reld = 0; m_scan = 8'h00;
  endfunction

  // One PS/2 bit: data changes while clock is high, optional sub-filter glitch, then a low phase.
  task automatic send_bit(input logic v, input bit glitch);
    int h, l;
    h = $urandom_range(15, 30);
    l = $urandom_range(18, 30);
    @(negedge clk) ps2data_in = v;
    repeat (h) @(negedge clk);
    if (glitch) begin
      ps2clk_in = 1'b0;
      repeat ($urandom_range(1, FL - 2)) @(negedge clk);
      ps2clk_in = 1'b1;
      repeat (h) @(negedge clk);
    end
    ps2clk_in = 1'b0;
    repeat (l) @(negedge clk);
    ps2clk_in = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 bad stop, 3 good with clock glitches. Sends the first n bits.
  task automatic send_bits(input logic [7:0] b, input int kind, input int n);
    logic [10:0] fr;
    logic par;
    par = ~(^b);
    if (kind == 1) par = ~par;
    fr = {(kind == 2) ? 1'b0 : 1'b1, par, b, 1'b0};
    for (int i = 0; i < n; i++) send_bit(fr[i], kind == 3);
    @(negedge clk) ps2data_in = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input int kind, input string tag);
    int r0, e0, exp_r, exp_e;
    r0 = rcv_cycles;
    e0 = err_cycles;
    send_bits(b, kind, 11);
    repeat (60) @(negedge clk);
    if (kind == 1 || kind == 2) begin
      exp_e = 1; exp_r = 0; m_ext = 0; m_rel = 0;
    end else begin
      exp_e = 0; exp_r = model_good(b) ? 1 : 0;
    end
    check({tag, ".rcv"}, rcv_cycles - r0, exp_r);
    check({tag, ".err"}, err_cycles - e0, exp_e);
    check({tag, ".scan"}, scan, m_scan);
    check({tag, ".ext"}, extended, m_extd);
    check({tag, ".rel"}, released, m_reld);
    check({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    int r0, e0, sel, kind;
    logic [7:0] b;
    logic [7:0] resp [6];
    resp = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    model_reset();

    // Reset with lines low; lines go idle at release.
    rst = 1'b1; ps2clk_in = 1'b0; ps2data_in = 1'b0;
    repeat (12) @(negedge clk);
    check("rst.scan", scan, 0);
    check("rst.flags", {extended, released, scan_received, frame_error, busy}, 0);
    @(negedge clk) begin rst = 1'b0; ps2clk_in = 1'b1; ps2data_in = 1'b1; end
    r0 = rcv_cycles; e0 = err_cycles;
    @(negedge clk);
    check("rel.outs", {scan, extended, released, scan_received, frame_error, busy}, 0);
    repeat (40) @(negedge clk);
    check("rel.quiet", (rcv_cycles - r0) + (err_cycles - e0) + busy, 0);

    // Directed scenarios.
    run_frame(8'h1C, 0, "plain1C");
    run_frame(8'hF0, 0, "brkF0");
    run_frame(8'h1C, 0, "brk1C");
    run_frame(8'hE0, 0, "extE0");
    run_frame(8'hF0, 0, "extF0");
    run_frame(8'h75, 0, "ext75");
    run_frame(8'h75, 0, "after75");
    run_frame(8'hF0, 0, "idemF0a");
    run_frame(8'hF0, 0, "idemF0b");
    run_frame(8'hE0, 0, "idemE0");
    run_frame(8'h6B, 0, "idem6B");
    run_frame(8'h1C, 1, "badpar");
    run_frame(8'hE0, 0, "pfxE0");
    run_frame(8'h5A, 2, "badstop");
    run_frame(8'h5A, 0, "afterstop");

    // Timeout: start + 4 data bits, then the clock stays high.
    run_frame(8'hE0, 0, "toE0");
    r0 = rcv_cycles; e0 = err_cycles;
    send_bits(8'h29, 0, 5);
    check("to.busy_mid", busy, 1);
    repeat (TO + 10) @(negedge clk);
    m_ext = 0; m_rel = 0;
    check("to.err", err_cycles - e0, 1);
    check("to.rcv", rcv_cycles - r0, 0);
    check("to.busy", busy, 0);
    run_frame(8'h29, 0, "after_to");

    // Glitches on the clock line must not shift extra bits.
    run_frame(8'hAA, 3, "glitchAA");
    run_frame(8'h16, 3, "glitch16");

    // Reset mid-frame: no pulses, outputs back to reset values.
    run_frame(8'hF0, 0, "preRstF0");
    r0 = rcv_cycles; e0 = err_cycles;
    send_bits(8'h33, 0, 6);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (40) @(negedge clk);
    check("midrst.pulses", (rcv_cycles - r0) + (err_cycles - e0), 0);
    check("midrst.outs", {scan, extended, released, busy}, 0);
    run_frame(8'h33, 0, "postRst33");

    // Random frames against the model.
    for (int i = 0; i < 24; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 8'hE0;
      else if (sel == 1) b = 8'hF0;
      else if (sel == 2) b = resp[$urandom_range(0, 5)];
      else b = 8'($urandom);
      kind = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : ($urandom_range(0, 3) == 0 ? 3 : 0);
      run_frame(b, kind, $sformatf("rnd%0d", i));
    end

    check("never_both", both_cycles, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_scan_decoder.md
PS2_SCAN_DECODER -- requirements
Module: ps2_scan_decoder

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8, the number of consecutive agreeing synchronized samples needed to change the filtered PS/2 clock level.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 28000, the maximum clk cycles allowed between falling edges within one frame.
REQ-003 clk  input  1  system clock; one clock domain only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 ps2clk_in  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 ps2data_in  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 scan_received  output  1  one-clk pulse: a complete scancode is valid.
REQ-008 scan  output  8  last emitted scancode byte; held until the next emission.
REQ-009 extended  output  1  last emitted code was preceded by 0xE0; held with scan.
REQ-010 released  output  1  last emitted code was preceded by 0xF0; held with scan.
REQ-011 frame_error  output  1  one-clk pulse on a parity, stop-bit or timeout error.
REQ-012 busy  output  1  high while a frame is in progress (any state except IDLE).

Function
REQ-013 ps2clk_in and ps2data_in SHALL each pass through a 2-flop synchronizer before any other use.
REQ-014 The filtered clock level SHALL change only when the last FILTER_LEN synchronized clock samples all equal the new level.
REQ-015 A falling edge SHALL be a filtered-level 1->0 transition; the synchronized data bit SHALL be sampled in that same cycle.
REQ-016 The frame FSM SHALL have states IDLE, DATA, PARITY and STOP.
REQ-017 IDLE: on a falling edge with data=0 (start bit), go to DATA with bit counter 0; a falling edge with data=1 SHALL be ignored.
REQ-018 DATA: shift 8 bits LSB first, one per falling edge; after the 8th bit go to PARITY.
REQ-019 PARITY: capture the bit and require odd parity over the 8 data bits plus parity; go to STOP.
REQ-020 STOP: require data=1 and good parity; return to IDLE.
REQ-021 If the stop bit is 0 or parity is bad, frame_error SHALL pulse one clk, the byte SHALL be discarded, and the prefix flags SHALL be cleared.
REQ-022 Timeout counter: cleared on each falling edge and held at 0 in IDLE. If it reaches TIMEOUT_CYCLES outside IDLE, the FSM SHALL go to IDLE, frame_error SHALL pulse, and the prefix flags SHALL clear.
REQ-023 For a good byte, 0xE0 SHALL set the internal ext_pending flag and emit nothing.
REQ-024 For a good byte, 0xF0 SHALL set the internal rel_pending flag and emit nothing.
REQ-025 Good bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE and 0xFF SHALL be treated as device responses: no emission, and both pending flags cleared.
REQ-026 Any other good byte SHALL produce these updates in the clk after the stop-bit falling edge:
- scan = byte
- extended = ext_pending
- released = rel_pending
- scan_received = 1 for exactly one clk
- both pending flags cleared
REQ-027 E0 followed by F0 in either order SHALL set both flags; a repeated prefix SHALL be idempotent.
REQ-028 Minimum spacing between scan_received pulses SHALL be one full frame; pulses SHALL never be back-to-back.
REQ-029 scan_received and frame_error SHALL never be asserted in the same cycle.

Reset
REQ-030 During rst=1 and in the cycle after:
- FSM = IDLE, bit counter = 0, timeout counter = 0
- scan = 0x00, extended = 0, released = 0
- scan_received = 0, frame_error = 0, busy = 0
- both pending flags cleared
REQ-031 During reset, the synchronizer and filter SHALL load 1 (idle bus), so a low line at reset release produces no spurious falling edge.
REQ-032 A reset asserted mid-frame SHALL abort the frame with no emission and no frame_error pulse.

Verification
REQ-033 Frame 0x1C, good odd parity -> one scan_received pulse; scan=0x1C, extended=0, released=0.
REQ-034 Frames F0, 1C -> single pulse with scan=0x1C, released=1, extended=0; both flags then clear.
REQ-035 Frames E0, F0, 75 -> single pulse with scan=0x75, extended=1, released=1; the following frame 75 emits extended=0, released=0.
REQ-036 Frame 0x1C with flipped parity -> frame_error pulse, no scan_received, scan keeps its prior value.
REQ-037 Start bit plus 4 data bits, then the clock held high for TIMEOUT_CYCLES+10 -> frame_error pulse, busy drops, and the next valid frame 0x29 emits scan=0x29.
REQ-038 Glitches on ps2clk_in shorter than FILTER_LEN-1 clks, plus frame 0xAA -> no bit shifted on glitches, no emission for 0xAA; the next valid 0x16 emits correctly.
